// File: rtl/keypad_matrix_scanner.sv
// ROWSxCOLS keypad scanner: one-hot word-line drive, synchronised bit-line sense,
// whole-frame debounce, and one key code per press over a valid/ready handshake.
module keypad_matrix_scanner #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  localparam int unsigned KEY_W         = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROWS-1:0]  o_word_lines,
  input  logic [COLS-1:0]  i_bit_lines,
  output logic             o_key_valid,
  output logic [KEY_W-1:0] o_key_code,
  input  logic             i_key_ready,
  output logic             o_multi_key,
  output logic             o_any_pressed,
  output logic             o_overrun
);

  localparam int unsigned NKEYS   = ROWS * COLS;
  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W   = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int unsigned POP_W   = $clog2(NKEYS + 1);

  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_HELD     = 1'b1
  } state_t;

  logic [COLS-1:0]    sync1_q, sync1_d;
  logic [COLS-1:0]    sync2_q, sync2_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [ROWS-1:0]    word_lines_q, word_lines_d;
  logic [NKEYS-1:0]   snap_q, snap_d;
  logic [NKEYS-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]   stable_q, stable_d;
  logic [NKEYS-1:0]   deb_q, deb_d;
  logic               any_q, any_d;
  logic               multi_q, multi_d;
  state_t             state_q, state_d;
  logic               key_valid_q, key_valid_d;
  logic [KEY_W-1:0]   key_code_q, key_code_d;
  logic               overrun_q, overrun_d;

  logic               frame_end_c;
  logic [POP_W-1:0]   pop_c;
  logic [KEY_W-1:0]   idx_c;
  logic               emit_c;

  // Row scan, snapshot capture and frame debounce.
  always_comb begin : scan_comb
    sync1_d     = i_bit_lines;
    sync2_d     = sync1_q;
    dwell_d     = dwell_q + 1'b1;
    row_d       = row_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    deb_d       = deb_q;
    frame_end_c = 1'b0;

    if (dwell_q == DWELL_W'(SCAN_DIV - 1)) begin
      dwell_d = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (row_q == ROW_W'(r)) begin
          snap_d[r*COLS +: COLS] = sync2_q;
        end
      end
      if (row_q == ROW_W'(ROWS - 1)) begin
        row_d       = '0;
        frame_end_c = 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    // The frame just completed includes the row captured this cycle, so compare snap_d.
    if (frame_end_c) begin
      if (snap_d == prev_q) begin
        stable_d = (stable_q == CNT_W'(DEBOUNCE_SCANS - 1)) ? stable_q : stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
      prev_d = snap_d;
      if (stable_d == CNT_W'(DEBOUNCE_SCANS - 1)) begin
        deb_d = snap_d;
      end
    end

    word_lines_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      word_lines_d[r] = (row_d == ROW_W'(r));
    end
  end

  // Key count and index of the debounced frame.
  always_comb begin : status_comb
    pop_c = '0;
    idx_c = '0;
    for (int i = 0; i < NKEYS; i++) begin
      pop_c = pop_c + POP_W'(deb_q[i]);
      if (deb_q[i]) begin
        idx_c = KEY_W'(i);
      end
    end
    any_d   = |deb_q;
    multi_d = (pop_c > POP_W'(1));
  end

  // Press tracking and output handshake.
  always_comb begin : fsm_comb
    state_d     = state_q;
    emit_c      = 1'b0;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = 1'b0;

    case (state_q)
      ST_RELEASED: begin
        if (pop_c == POP_W'(1)) begin
          emit_c  = 1'b1;
          state_d = ST_HELD;
        end else if (pop_c > POP_W'(1)) begin
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (deb_q == '0) begin
          state_d = ST_RELEASED;
        end
      end
      default: state_d = ST_RELEASED;
    endcase

    if (key_valid_q && i_key_ready) begin
      key_valid_d = 1'b0;
    end
    if (emit_c) begin
      if (!key_valid_q || i_key_ready) begin
        key_valid_d = 1'b1;
        key_code_d  = idx_c;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      row_q        <= '0;
      dwell_q      <= '0;
      word_lines_q <= ROWS'(1);
      snap_q       <= '0;
      prev_q       <= '0;
      stable_q     <= '0;
      deb_q        <= '0;
      any_q        <= 1'b0;
      multi_q      <= 1'b0;
      state_q      <= ST_RELEASED;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      word_lines_q <= word_lines_d;
      snap_q       <= snap_d;
      prev_q       <= prev_d;
      stable_q     <= stable_d;
      deb_q        <= deb_d;
      any_q        <= any_d;
      multi_q      <= multi_d;
      state_q      <= state_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_word_lines  = word_lines_q;
  assign o_key_valid   = key_valid_q;
  assign o_key_code    = key_code_q;
  assign o_multi_key   = multi_q;
  assign o_any_pressed = any_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: key-matrix model on the pads, frame-level reference
// model of debounce/press/handshake, directed table, hand sequences and random presses.
module tb_keypad_matrix_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SDIV  = 4;
  localparam int DEB   = 2;
  localparam int NK    = ROWS * COLS;
  localparam int FRAME = ROWS * SDIV;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [ROWS-1:0] o_word_lines;
  logic [COLS-1:0] bit_lines;
  logic            o_key_valid;
  logic [3:0]      o_key_code;
  logic            i_key_ready = 1'b1;
  logic            o_multi_key;
  logic            o_any_pressed;
  logic            o_overrun;
  logic [NK-1:0]   keys = '0;

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk), .rst(rst),
    .o_word_lines(o_word_lines), .i_bit_lines(bit_lines),
    .o_key_valid(o_key_valid), .o_key_code(o_key_code), .i_key_ready(i_key_ready),
    .o_multi_key(o_multi_key), .o_any_pressed(o_any_pressed), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its driven word line onto its bit line.
  always_comb begin
    bit_lines = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (o_word_lines[r] && keys[r*COLS+c]) bit_lines[c] = 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int got_q[$];
  int exp_q[$];
  int ovr_got = 0;
  int ovr_exp = 0;
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_deb;
  bit m_held, m_pend;

  typedef struct {
    logic [NK-1:0] k;
    int            frames;
    logic          rdy;
    logic          exp_any;
    logic          exp_multi;
    int            ncodes;
    int            code;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    if (m_pend) void'(exp_q.pop_back());
    hist.delete();
    hist.push_back('0);
    m_deb  = '0;
    m_held = 0;
    m_pend = 0;
  endtask

  // Debounced state = frame once the last DEB frames agree; one code per press.
  task automatic model_frame(input logic [NK-1:0] f, input logic rdy);
    bit stable;
    int pc;
    int idx;
    hist.push_back(f);
    while (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != f) stable = 0;
    if (!stable) return;
    m_deb = f;
    pc = $countones(f);
    idx = 0;
    for (int i = 0; i < NK; i++) if (f[i]) idx = i;
    if (!m_held) begin
      if (pc == 1) begin
        m_held = 1;
        if (m_pend) ovr_exp++;
        else begin
          exp_q.push_back(idx);
          m_pend = !rdy;
        end
      end else if (pc > 1) begin
        m_held = 1;
      end
    end else if (pc == 0) begin
      m_held = 0;
    end
  endtask

  task automatic tick();
    if (o_key_valid && i_key_ready) got_q.push_back(int'(o_key_code));
    @(negedge clk);
    cyc++;
    if (o_overrun) ovr_got++;
    chk("word_lines", int'(o_word_lines), 1 << ((cyc / SDIV) % ROWS));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    model_reset();
    chk("rst_word_lines", int'(o_word_lines), 1);
    chk("rst_valid", int'(o_key_valid), 0);
    chk("rst_code", int'(o_key_code), 0);
    chk("rst_multi", int'(o_multi_key), 0);
    chk("rst_any", int'(o_any_pressed), 0);
    chk("rst_overrun", int'(o_overrun), 0);
  endtask

  task automatic run_frame(input logic [NK-1:0] f, input logic rdy);
    keys = f;
    tick();
    chk("any_pressed", int'(o_any_pressed), int'(m_deb != '0));
    chk("multi_key", int'(o_multi_key), int'($countones(m_deb) > 1));
    tick();
    i_key_ready = rdy;
    if (rdy) m_pend = 0;
    repeat (FRAME - 2) tick();
    model_frame(f, rdy);
  endtask

  task automatic check_codes(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_code"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base;
    logic [NK-1:0] pat;
    int a, b, nfr;
    logic rdy;

    vecs[0]  = '{16'h0000, 3, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{16'h0200, 3, 1'b1, 1'b1, 1'b0, 1, 9};
    vecs[2]  = '{16'h0000, 3, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{16'h1080, 3, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[4]  = '{16'h0000, 3, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{16'h0020, 3, 1'b1, 1'b1, 1'b0, 1, 5};
    vecs[6]  = '{16'h0060, 3, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[7]  = '{16'h0040, 3, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[8]  = '{16'h0000, 3, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[9]  = '{16'h0040, 3, 1'b1, 1'b1, 1'b0, 1, 6};
    vecs[10] = '{16'h0000, 3, 1'b1, 1'b0, 1'b0, 0, 0};

    // Idle scan with no keys.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_valid", int'(o_key_valid), 0);
      chk("idle_any", int'(o_any_pressed), 0);
    end

    // Directed press table.
    do_reset();
    got_q.delete();
    foreach (vecs[v]) begin
      base = got_q.size();
      for (int f = 0; f < vecs[v].frames; f++) run_frame(vecs[v].k, vecs[v].rdy);
      chk($sformatf("vec%0d_any", v), int'(o_any_pressed), int'(vecs[v].exp_any));
      chk($sformatf("vec%0d_multi", v), int'(o_multi_key), int'(vecs[v].exp_multi));
      chk($sformatf("vec%0d_ncodes", v), got_q.size() - base, vecs[v].ncodes);
      if (vecs[v].ncodes > 0) chk($sformatf("vec%0d_code", v), got_q[got_q.size()-1], vecs[v].code);
    end
    check_codes("table");

    // Bouncing r0c0, toggling every 5 clk for two frames, then steady.
    do_reset();
    i_key_ready = 1'b1;
    for (int t = 0; t < 2 * FRAME; t++) begin
      keys = (((t / 5) % 2) == 0) ? NK'(1) : NK'(0);
      tick();
      chk("bounce_valid", int'(o_key_valid), 0);
    end
    repeat (3) run_frame(NK'(1), 1'b1);
    chk("bounce_ncodes", got_q.size(), 1);
    if (got_q.size() > 0) chk("bounce_code", got_q[0], 0);
    repeat (3) run_frame('0, 1'b1);
    chk("bounce_release_any", int'(o_any_pressed), 0);
    check_codes("bounce");

    // Consumer stalled: second press overruns while code 1 pends.
    do_reset();
    repeat (3) run_frame(NK'(1) << 1, 1'b0);
    repeat (3) run_frame('0, 1'b0);
    repeat (3) run_frame(NK'(1) << 15, 1'b0);
    repeat (3) run_frame('0, 1'b0);
    chk("stall_valid", int'(o_key_valid), 1);
    chk("stall_code", int'(o_key_code), 1);
    chk("stall_overruns", ovr_got, 1);
    chk("stall_overruns_model", ovr_got, ovr_exp);
    run_frame('0, 1'b1);
    chk("stall_drain_valid", int'(o_key_valid), 0);
    chk("stall_drain_ncodes", got_q.size(), 1);
    check_codes("stall");

    // Reset mid-frame with a code pending and the key still held.
    do_reset();
    repeat (3) run_frame(NK'(1) << 10, 1'b0);
    repeat (7) tick();
    chk("pre_rst_valid", int'(o_key_valid), 1);
    do_reset();
    repeat (3) run_frame(NK'(1) << 10, 1'b1);
    chk("rst_reemit_ncodes", got_q.size(), 1);
    if (got_q.size() > 0) chk("rst_reemit_code", got_q[0], 10);
    repeat (3) run_frame('0, 1'b1);
    check_codes("reset");

    // Random press patterns and consumer stalls against the reference model.
    do_reset();
    ovr_got = 0;
    ovr_exp = 0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: pat = '0;
        1: pat = NK'(1) << $urandom_range(0, NK - 1);
        2: begin
          a = $urandom_range(0, NK - 1);
          b = (a + $urandom_range(1, NK - 1)) % NK;
          pat = (NK'(1) << a) | (NK'(1) << b);
        end
        default: pat = NK'($urandom);
      endcase
      nfr = $urandom_range(1, 4);
      rdy = ($urandom_range(0, 3) != 0);
      for (int f = 0; f < nfr; f++) run_frame(pat, rdy);
    end
    repeat (4) run_frame('0, 1'b1);
    check_codes("random");
    chk("random_overruns", ovr_got, ovr_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
